// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding, load-use stall and flush bubbles.
// Optional IDEX_PERF_CNT_EN adds saturating stall_cnt/flush_cnt event counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_d,
  input  logic            alusrc_d,
  input  logic [2:0]      alucontrol_d,
  input  logic            regwrite_d,
  input  logic            memwrite_d,
  input  logic            branch_d,
  input  logic [1:0]      resultsrc_d,
  input  logic            flush_e,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [XLEN-1:0] result_w,
  input  logic [REGW-1:0] rd_m,
  input  logic [REGW-1:0] rd_w,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  output logic [XLEN-1:0] srca_e,
  output logic [XLEN-1:0] srcb_e,
  output logic [2:0]      alucontrol_e,
  output logic [XLEN-1:0] writedata_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [REGW-1:0] rd_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic [1:0]      resultsrc_e,
  output logic            valid_e,
  output logic            stall_d
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [XLEN-1:0] rd1_e, rd2_e;
  logic [REGW-1:0] rs1_e, rs2_e;
  logic            alusrc_e;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // A load in EX cannot forward its data until MEM completes, so decode must wait.
  assign stall_d = valid_e && (resultsrc_e == 2'b01) && (rd_e != '0) && valid_d &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e      <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      pc_e         <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      alusrc_e     <= 1'b0;
      alucontrol_e <= 3'b000;
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      branch_e     <= 1'b0;
      resultsrc_e  <= 2'b00;
    end else if (flush_e || stall_d) begin
      valid_e      <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      pc_e         <= '0;
      pcplus4_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      alusrc_e     <= 1'b0;
      alucontrol_e <= 3'b000;
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      branch_e     <= 1'b0;
      resultsrc_e  <= 2'b00;
    end else begin
      valid_e      <= valid_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      imm_ext_e    <= imm_ext_d;
      pc_e         <= pc_d;
      pcplus4_e    <= pcplus4_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      alusrc_e     <= alusrc_d;
      alucontrol_e <= alucontrol_d;
      regwrite_e   <= regwrite_d;
      memwrite_e   <= memwrite_d;
      branch_e     <= branch_d;
      resultsrc_e  <= resultsrc_d;
    end
  end

  // MEM is the younger producer, so it overrides WB; x0 is never forwarded.
  always_comb begin
    fwd_a = rd1_e;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e))
      fwd_a = aluresult_m;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e))
      fwd_a = result_w;
  end

  always_comb begin
    fwd_b = rd2_e;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e))
      fwd_b = aluresult_m;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e))
      fwd_b = result_w;
  end

  assign srca_e      = fwd_a;
  assign srcb_e      = alusrc_e ? imm_ext_e : fwd_b;
  assign writedata_e = fwd_b;

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_d && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_e && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the EX stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pcplus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        alusrc_d;
  logic [2:0]  alucontrol_d;
  logic        regwrite_d, memwrite_d, branch_d;
  logic [1:0]  resultsrc_d;
  logic        flush_e;
  logic [31:0] aluresult_m, result_w;
  logic [4:0]  rd_m, rd_w;
  logic        regwrite_m, regwrite_w;
  logic [31:0] srca_e, srcb_e, writedata_e, pc_e, pcplus4_e, imm_ext_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  rd_e;
  logic        regwrite_e, memwrite_e, branch_e, valid_e, stall_d;
  logic [1:0]  resultsrc_e;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] stall_cnt_m = 0, flush_cnt_m = 0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d),
    .rs2_d(rs2_d), .rd_d(rd_d), .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
    .resultsrc_d(resultsrc_d), .flush_e(flush_e), .aluresult_m(aluresult_m),
    .result_w(result_w), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .srca_e(srca_e), .srcb_e(srcb_e),
    .alucontrol_e(alucontrol_e), .writedata_e(writedata_e), .pc_e(pc_e),
    .pcplus4_e(pcplus4_e), .imm_ext_e(imm_ext_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
    .resultsrc_e(resultsrc_e), .valid_e(valid_e), .stall_d(stall_d)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        alusrc;
    logic [2:0]  ctl;
    logic        rw, mw, br;
    logic [1:0]  rsrc;
  } ex_t;

  ex_t m = '0;

  function automatic logic model_stall();
    return m.valid && m.rsrc == 2'b01 && m.rd != 0 && valid_d &&
           (m.rd == rs1_d || m.rd == rs2_d);
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] regval);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return aluresult_m;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return result_w;
    return regval;
  endfunction

  task automatic clear_inputs();
    valid_d = 0; rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0; pcplus4_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; alusrc_d = 0; alucontrol_d = 0;
    regwrite_d = 0; memwrite_d = 0; branch_d = 0; resultsrc_d = 0; flush_e = 0;
    aluresult_m = 0; result_w = 0; rd_m = 0; rd_w = 0; regwrite_m = 0; regwrite_w = 0;
  endtask

  task automatic random_inputs();
    valid_d = ($urandom_range(0, 9) != 0);
    rd1_d = $urandom; rd2_d = $urandom; imm_ext_d = $urandom;
    pc_d = $urandom; pcplus4_d = pc_d + 4;
    rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
    rd_d = 5'($urandom_range(0, 7));
    alusrc_d = 1'($urandom); alucontrol_d = 3'($urandom_range(0, 5));
    regwrite_d = 1'($urandom); memwrite_d = 1'($urandom); branch_d = 1'($urandom);
    resultsrc_d = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom);
    flush_e = ($urandom_range(0, 7) == 0);
    aluresult_m = $urandom; result_w = $urandom;
    rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
    regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
  endtask

  // Advance one clock; the model applies the bubble/capture rule to the inputs present at the edge.
  task automatic tick();
    ex_t nxt;
    logic st;
    st = model_stall();
    nxt = '0;
    if (!(flush_e || st)) begin
      nxt.valid = valid_d; nxt.rd1 = rd1_d; nxt.rd2 = rd2_d; nxt.imm = imm_ext_d;
      nxt.pc = pc_d; nxt.pc4 = pcplus4_d; nxt.rs1 = rs1_d; nxt.rs2 = rs2_d;
      nxt.rd = rd_d; nxt.alusrc = alusrc_d; nxt.ctl = alucontrol_d;
      nxt.rw = regwrite_d; nxt.mw = memwrite_d; nxt.br = branch_d; nxt.rsrc = resultsrc_d;
    end
`ifdef IDEX_PERF_CNT_EN
    if (rst) begin
      if (st && stall_cnt_m != 32'hFFFF_FFFF) stall_cnt_m++;
      if (flush_e && flush_cnt_m != 32'hFFFF_FFFF) flush_cnt_m++;
    end
`endif
    if (!rst) nxt = '0;
    @(posedge clk);
    #1;
    m = nxt;
  endtask

  task automatic test_reset();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      #1;
      checks++;
      if ({valid_e, regwrite_e, memwrite_e, branch_e, resultsrc_e, alucontrol_e, rd_e} !== '0 ||
          {srca_e, srcb_e, writedata_e, pc_e, pcplus4_e, imm_ext_e} !== '0 || stall_d !== 1'b0)
        begin errors++; $display("FAIL reset_state cycle %0d: valid_e=%b stall_d=%b srca=%h pc_e=%h required all zero",
                                 i, valid_e, stall_d, srca_e, pc_e); end
      tick();
    end
    clear_inputs();
    rst = 1;
    #1;
  endtask

  task automatic test_capture();
    clear_inputs(); tick();
    valid_d = 1; rd1_d = 5; imm_ext_d = 7; alusrc_d = 1; alucontrol_d = 3'b000; rs1_d = 1;
    tick();
    checks++;
    if (srca_e !== 32'd5 || srcb_e !== 32'd7 || alucontrol_e !== 3'b000 || valid_e !== 1'b1) begin
      errors++; $display("FAIL capture: srca=%h srcb=%h ctl=%b valid=%b required 5 7 000 1",
                         srca_e, srcb_e, alucontrol_e, valid_e);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    valid_d = 1; rs1_d = 3; rd1_d = 32'h11;
    tick();
    rd_m = 3; rd_w = 3; regwrite_m = 1; regwrite_w = 1; aluresult_m = 32'hAA; result_w = 32'hBB;
    #1; checks++;
    if (srca_e !== 32'hAA) begin errors++; $display("FAIL fwd_mem_priority: srca=%h required aa", srca_e); end
    regwrite_m = 0;
    #1; checks++;
    if (srca_e !== 32'hBB) begin errors++; $display("FAIL fwd_wb: srca=%h required bb", srca_e); end
    regwrite_m = 1; rd_m = 0; rd_w = 0;
    #1; checks++;
    if (srca_e !== 32'h11) begin errors++; $display("FAIL fwd_x0: srca=%h required 11", srca_e); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    valid_d = 1; resultsrc_d = 2'b01; rd_d = 4; regwrite_d = 1;
    tick();
    clear_inputs();
    valid_d = 1; rs1_d = 9; rs2_d = 4; memwrite_d = 1;
    #1; checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL load_use_stall: stall_d=%b required 1", stall_d); end
    tick();
    checks++;
    if (valid_e !== 1'b0 || memwrite_e !== 1'b0 || regwrite_e !== 1'b0 || stall_d !== 1'b0) begin
      errors++; $display("FAIL load_use_bubble: valid=%b mw=%b rw=%b stall=%b required 0 0 0 0",
                         valid_e, memwrite_e, regwrite_e, stall_d);
    end
    tick();
    checks++;
    if (valid_e !== 1'b1 || memwrite_e !== 1'b1) begin
      errors++; $display("FAIL load_use_resume: valid=%b mw=%b required 1 1", valid_e, memwrite_e);
    end
  endtask

  task automatic test_flush_stall();
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] s0, f0;
`endif
    clear_inputs();
    valid_d = 1; resultsrc_d = 2'b01; rd_d = 2; regwrite_d = 1;
    tick();
    clear_inputs();
    valid_d = 1; rs1_d = 2; regwrite_d = 1; flush_e = 1;
    #1; checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL flush_stall_cond: stall_d=%b required 1", stall_d); end
`ifdef IDEX_PERF_CNT_EN
    s0 = stall_cnt; f0 = flush_cnt;
`endif
    tick();
    checks++;
    if (valid_e !== 1'b0 || regwrite_e !== 1'b0 || stall_d !== 1'b0) begin
      errors++; $display("FAIL flush_stall_bubble: valid=%b rw=%b stall=%b required 0 0 0",
                         valid_e, regwrite_e, stall_d);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (stall_cnt !== s0 + 1 || flush_cnt !== f0 + 1) begin
      errors++; $display("FAIL perf_cnt_step: stall_cnt=%0d flush_cnt=%0d required %0d %0d",
                         stall_cnt, flush_cnt, s0 + 1, f0 + 1);
    end
`endif
    flush_e = 0;
    tick();
    checks++;
    if (valid_e !== 1'b1 || regwrite_e !== 1'b1) begin
      errors++; $display("FAIL flush_stall_single: valid=%b rw=%b required 1 1", valid_e, regwrite_e);
    end
  endtask

  task automatic test_store_forward();
    clear_inputs();
    valid_d = 1; rs2_d = 6; alusrc_d = 1; imm_ext_d = 32'h40; rd2_d = 32'h99; memwrite_d = 1;
    tick();
    clear_inputs();
    rd_m = 6; regwrite_m = 1; aluresult_m = 32'h1234;
    #1; checks++;
    if (writedata_e !== 32'h1234 || srcb_e !== 32'h40) begin
      errors++; $display("FAIL store_fwd: writedata=%h srcb=%h required 1234 40", writedata_e, srcb_e);
    end
  endtask

  task automatic test_midreset();
    clear_inputs();
    valid_d = 1; resultsrc_d = 2'b01; rd_d = 5; pc_d = 32'h100;
    tick();
    rs1_d = 5; valid_d = 1;
    #2; rst = 0; #1;
    checks++;
    if (valid_e !== 1'b0 || stall_d !== 1'b0 || pc_e !== 32'h0) begin
      errors++; $display("FAIL midreset: valid=%b stall=%b pc_e=%h required 0 0 0", valid_e, stall_d, pc_e);
    end
    m = '0;
`ifdef IDEX_PERF_CNT_EN
    stall_cnt_m = 0; flush_cnt_m = 0;
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++; $display("FAIL midreset_cnt: stall_cnt=%0d flush_cnt=%0d required 0 0", stall_cnt, flush_cnt);
    end
`endif
    tick();
    rst = 1;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      #1;
      ea = model_fwd(m.rs1, m.rd1);
      eb = model_fwd(m.rs2, m.rd2);
      checks++;
      if (stall_d !== model_stall()) begin
        errors++; $display("FAIL rnd_stall %0d: stall_d=%b required %b", i, stall_d, model_stall());
      end
      checks++;
      if (srca_e !== ea || srcb_e !== (m.alusrc ? m.imm : eb) || writedata_e !== eb) begin
        errors++; $display("FAIL rnd_operands %0d: a=%h b=%h wd=%h required %h %h %h", i,
                           srca_e, srcb_e, writedata_e, ea, m.alusrc ? m.imm : eb, eb);
      end
      checks++;
      if ({valid_e, pc_e, pcplus4_e, imm_ext_e, rd_e, alucontrol_e, regwrite_e, memwrite_e, branch_e, resultsrc_e} !==
          {m.valid, m.pc, m.pc4, m.imm, m.rd, m.ctl, m.rw, m.mw, m.br, m.rsrc}) begin
        errors++; $display("FAIL rnd_ex_reg %0d: v=%b pc=%h rd=%0d ctl=%b rw=%b mw=%b br=%b rs=%b required v=%b pc=%h rd=%0d ctl=%b rw=%b mw=%b br=%b rs=%b",
                           i, valid_e, pc_e, rd_e, alucontrol_e, regwrite_e, memwrite_e, branch_e, resultsrc_e,
                           m.valid, m.pc, m.rd, m.ctl, m.rw, m.mw, m.br, m.rsrc);
      end
`ifdef IDEX_PERF_CNT_EN
      checks++;
      if (stall_cnt !== stall_cnt_m || flush_cnt !== flush_cnt_m) begin
        errors++; $display("FAIL rnd_cnt %0d: stall_cnt=%0d flush_cnt=%0d required %0d %0d",
                           i, stall_cnt, flush_cnt, stall_cnt_m, flush_cnt_m);
      end
`endif
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_flush_stall();
    test_store_forward();
    test_random();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
